muldiv_ctrl: RTL

//  Sequencer for the RV32M multiply/divide unit. Accepts one M-extension op from the execute

---
 rtl/muldiv_ctrl_pkg.sv | 25 ++
 rtl/muldiv_ctrl_if.sv | 18 +
 rtl/MD_in.sv | 47 ++++
 rtl/muldiv_iter.sv | 47 ++++
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   XLEN     : operand/result width (RV32 only)
//   CNT_W    : width of the iteration counter
//   state_t  : sequencer states
//   OP_*     : md_op encodings, bit 2 selects the divider
//   neg_if   : conditional two's-complement negate used by sign fix-up
package muldiv_ctrl_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC, ST_FIX, ST_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  function automatic logic [2*XLEN-1:0] neg_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> mul/div unit handshake bundle.
//   start_i/md_op_i/rs1_i/rs2_i/kill_i : request side (driven by master)
//   busy_o/done_o/result_o             : response side (driven by slave)
interface muldiv_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                  start_i;
  logic [2:0]            md_op_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic                  kill_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (output start_i, md_op_i, rs1_i, rs2_i, kill_i,
                  input  busy_o, done_o, result_o);
  modport slave  (input  start_i, md_op_i, rs1_i, rs2_i, kill_i,
                  output busy_o, done_o, result_o);
endinterface

// File: rtl/MD_in.sv
// Operand conditioning for the mul/div datapath.
//   op_i                 : {word_op(tied 0 on RV32), md_op[2:0]}
//   rs1_i, rs2_i         : raw operands
//   X_o, Y_o             : magnitudes for signed operands, raw value otherwise
//   d_exception_o        : divide-by-zero or most-negative/-1 pattern seen (op-agnostic;
//                          the sequencer decides whether it applies)
//   d_exception_result_o : architectural result for the flagged case
module MD_in import muldiv_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic [DATA_WIDTH-1:0] X_o,
  output logic [DATA_WIDTH-1:0] Y_o,
  output logic                  d_exception_o,
  output logic [DATA_WIDTH-1:0] d_exception_result_o
);
  localparam int W = DATA_WIDTH;

  logic x_signed, y_signed, div_zero, div_ovf, unused_op3;

  assign unused_op3 = op_i[3];

  always_comb begin
    x_signed = 1'b0;
    y_signed = 1'b0;
    unique case (op_i[2:0])
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin x_signed = 1'b1; y_signed = 1'b1; end
      OP_MULHSU:                       x_signed = 1'b1;
      default:                         ;
    endcase
  end

  assign X_o = (x_signed && rs1_i[W-1]) ? -rs1_i : rs1_i;
  assign Y_o = (y_signed && rs2_i[W-1]) ? -rs2_i : rs2_i;

  assign div_zero      = ~|rs2_i;
  assign div_ovf       = (rs1_i == {1'b1, {(W-1){1'b0}}}) && (&rs2_i);
  assign d_exception_o = div_zero | div_ovf;

  // op_i[1] distinguishes REM* from DIV*
  always_comb begin
    if (div_zero) d_exception_result_o = op_i[1] ? rs1_i : '1;
    else          d_exception_result_o = op_i[1] ? '0    : rs1_i;
  end
endmodule

// File: rtl/muldiv_iter.sv
// Shared 2W+1-bit accumulator for shift-add multiply / restoring divide.
//   load_i/init_i : seed the accumulator
//   step_i        : advance one bit (div_i selects divide step)
//   opnd_i        : multiplicand (mul) or divisor (div)
//   acc_o         : mul -> product in [2W-1:0]; div -> remainder [2W-1:W], quotient [W-1:0]
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         div_i,
  input  logic [2*W:0] init_i,
  input  logic [W-1:0] opnd_i,
  output logic [2*W:0] acc_o
);
  logic [2*W:0] acc_q, acc_n, sh;
  logic [W:0]   hi;

  always_comb begin
    acc_n = acc_q;
    sh    = '0;
    hi    = '0;
    if (div_i) begin
      sh = acc_q << 1;
      if (sh[2*W:W] >= {1'b0, opnd_i}) begin
        sh[2*W:W] = sh[2*W:W] - {1'b0, opnd_i};
        sh[0]     = 1'b1;
      end
      acc_n = sh;
    end else begin
      // hi never overflows: its MSB is 0 after each right shift
      hi = acc_q[2*W:W];
      if (acc_q[0]) hi = hi + {1'b0, opnd_i};
      acc_n = {hi, acc_q[W-1:0]} >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)    acc_q <= '0;
    else if (load_i) acc_q <= init_i;
    else if (step_i) acc_q <= acc_n;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: IDLE -> CALC(32) -> FIX -> DONE, or IDLE -> DONE
// for divide-by-zero / signed overflow.
//   clk_i   : clock
//   reset_i : async active-low reset
//   bus     : muldiv_ctrl_if slave (start/op/operands/kill in, busy/done/result out)
module muldiv_ctrl import muldiv_ctrl_pkg::*; #(
  parameter int DATA_WIDTH = XLEN
) (
  input logic          clk_i,
  input logic          reset_i,
  muldiv_ctrl_if.slave bus
);
  localparam int W = DATA_WIDTH;

  state_t           state;
  logic [2:0]       op_q;
  logic [W-1:0]     x_q, y_q, x_c, y_c, exc_res, result_q;
  logic             xs_q, ys_q, busy_q, done_q, md_exc, exc, accept;
  logic [CNT_W-1:0] cnt;
  logic [2*W:0]     acc;
  logic [2*W-1:0]   src, fixed;
  logic             neg, unused_acc_msb;
  logic [W-1:0]     fix_val;

  MD_in #(.DATA_WIDTH(W)) u_md_in (
    .op_i                 ({1'b0, bus.md_op_i}),
    .rs1_i                (bus.rs1_i),
    .rs2_i                (bus.rs2_i),
    .X_o                  (x_c),
    .Y_o                  (y_c),
    .d_exception_o        (md_exc),
    .d_exception_result_o (exc_res)
  );

  // Only divides take the exception path; overflow only matters for the signed ones.
  assign exc    = bus.md_op_i[2] & md_exc & (~bus.md_op_i[0] | ~|bus.rs2_i);
  assign accept = (state == ST_IDLE) & bus.start_i & ~bus.kill_i;

  muldiv_iter #(.W(W)) u_iter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept & ~exc),
    .step_i  (state == ST_CALC),
    .div_i   (op_q[2]),
    .init_i  (bus.md_op_i[2] ? {{(W+1){1'b0}}, x_c} : {{(W+1){1'b0}}, y_c}),
    .opnd_i  (op_q[2] ? y_q : x_q),
    .acc_o   (acc)
  );

  assign unused_acc_msb = acc[2*W];

  // Sign fix-up on the unsigned magnitude result
  always_comb begin
    unique case (op_q)
      OP_MUL, OP_MULH, OP_DIV: neg = xs_q ^ ys_q;
      OP_MULHSU, OP_REM:       neg = xs_q;
      default:                 neg = 1'b0;
    endcase
    if (!op_q[2])     src = acc[2*W-1:0];
    else if (op_q[1]) src = {{W{1'b0}}, acc[2*W-1:W]};
    else              src = {{W{1'b0}}, acc[W-1:0]};
    fixed   = neg_if(src, neg);
    fix_val = (!op_q[2] && op_q[1:0] != 2'b00) ? fixed[2*W-1:W] : fixed[W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.kill_i) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            op_q   <= bus.md_op_i;
            x_q    <= x_c;
            y_q    <= y_c;
            xs_q   <= bus.rs1_i[W-1];
            ys_q   <= bus.rs2_i[W-1];
            cnt    <= '0;
            busy_q <= 1'b1;
            if (exc) begin
              result_q <= exc_res;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_val;
          done_q   <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule
